// File: rtl/out_port_sched_pkg.sv
// Shared types and default sizing for the output-port packet scheduler.
package sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

  localparam int NUM_OF_PRIORITY_DEF = 8;
  localparam int PRIORITY_WIDTH_DEF  = 3;
  localparam int WEIGHT_WIDTH_DEF    = 4;

endpackage

// File: rtl/out_port_sched_rot_pick.sv
// Combinational rotating picker: returns the first set request bit found by
// scanning downward from ptr, wrapping from 0 to num_of_priority-1.
module rot_pick
  import sched_pkg::*;
#(
  parameter int num_of_priority = NUM_OF_PRIORITY_DEF,
  parameter int priority_width  = PRIORITY_WIDTH_DEF
) (
  input  logic [num_of_priority-1:0] req,
  input  logic [priority_width-1:0]  ptr,
  output logic [priority_width-1:0]  idx,
  output logic                       found
);

  int j;

  // Scan from farthest to nearest so the position closest to ptr wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = num_of_priority - 1; k >= 0; k--) begin
      j = int'(ptr) - k;
      if (j < 0) j = j + num_of_priority;
      if (req[j[priority_width-1:0]]) begin
        idx   = j[priority_width-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_port_sched.sv
// Per-output-port packet scheduler: picks the next priority queue to drain,
// one whole packet per grant, by strict priority or weighted round robin.
// Optional feature macro: SCHED_WRR_EN (WRR credits, rr_ptr and weight decode).
// Without it the block is strict priority only.
module out_port_sched
  import sched_pkg::*;
#(
  parameter int num_of_priority = NUM_OF_PRIORITY_DEF,
  parameter int priority_width  = PRIORITY_WIDTH_DEF,
  parameter int weight_width    = WEIGHT_WIDTH_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    sp0_wrr1,
  input  logic [num_of_priority-1:0]              q_nonempty,
  input  logic [num_of_priority*weight_width-1:0] wrr_weight,
  input  logic                                    ready,
  input  logic                                    pkt_done,
  output logic                                    rd_gnt_vld,
  output logic [priority_width-1:0]               rd_gnt_pri,
  output logic                                    busy
);

  localparam logic [priority_width-1:0] LAST = priority_width'(num_of_priority - 1);

  sched_state_t              state;
  logic                      start;
  logic [priority_width-1:0] sp_idx;
  logic                      sp_found;
  logic [priority_width-1:0] pick_idx;

  assign start = (state == IDLE) && ready && (|q_nonempty);

  // Strict priority is a rotating pick pinned at the highest index.
  rot_pick #(
    .num_of_priority(num_of_priority),
    .priority_width (priority_width)
  ) u_sp_pick (
    .req  (q_nonempty),
    .ptr  (LAST),
    .idx  (sp_idx),
    .found(sp_found)
  );

`ifdef SCHED_WRR_EN
  logic [weight_width-1:0]   credit     [num_of_priority];
  logic [weight_width-1:0]   weight_dec [num_of_priority];
  logic [weight_width-1:0]   eff_credit [num_of_priority];
  logic [num_of_priority-1:0] elig;
  logic [num_of_priority-1:0] eff_elig;
  logic [priority_width-1:0] rr_ptr;
  logic [priority_width-1:0] eff_ptr;
  logic [priority_width-1:0] wrr_idx;
  logic                      wrr_found;
  logic                      mode_q;
  logic                      mode_rise;
  logic                      reload;

  // Decode weights (0 acts as 1) and form the credits arbitration sees this
  // cycle; a reload is used immediately rather than costing an extra cycle.
  always_comb begin
    mode_rise = sp0_wrr1 & ~mode_q;
    elig      = '0;
    eff_elig  = '0;
    for (int i = 0; i < num_of_priority; i++) begin
      weight_dec[i] = wrr_weight[i*weight_width +: weight_width];
      if (weight_dec[i] == '0) weight_dec[i] = weight_width'(1);
      elig[i] = q_nonempty[i] && (credit[i] != '0);
    end
    reload = mode_rise || (elig == '0);
    for (int i = 0; i < num_of_priority; i++) begin
      eff_credit[i] = reload ? weight_dec[i] : credit[i];
      eff_elig[i]   = q_nonempty[i] && (eff_credit[i] != '0);
    end
    eff_ptr = mode_rise ? LAST : rr_ptr;
  end

  rot_pick #(
    .num_of_priority(num_of_priority),
    .priority_width (priority_width)
  ) u_wrr_pick (
    .req  (eff_elig),
    .ptr  (eff_ptr),
    .idx  (wrr_idx),
    .found(wrr_found)
  );

  assign pick_idx = sp0_wrr1 ? wrr_idx : sp_idx;

  // Credit and rr_ptr bookkeeping, committed on the grant edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < num_of_priority; i++) credit[i] <= '0;
      rr_ptr <= LAST;
      mode_q <= 1'b0;
    end else if (state == IDLE) begin
      mode_q <= sp0_wrr1;
      if (start && sp0_wrr1) begin
        for (int i = 0; i < num_of_priority; i++) credit[i] <= eff_credit[i];
        credit[wrr_idx] <= eff_credit[wrr_idx] - weight_width'(1);
        if (eff_credit[wrr_idx] == weight_width'(1))
          rr_ptr <= (wrr_idx == '0) ? LAST : wrr_idx - 1'b1;
        else
          rr_ptr <= wrr_idx;
      end else if (mode_rise) begin
        for (int i = 0; i < num_of_priority; i++) credit[i] <= weight_dec[i];
        rr_ptr <= LAST;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = sp_found ^ wrr_found;
`else
  assign pick_idx = sp_idx;

  logic unused_ok;
  assign unused_ok = ^{sp0_wrr1, wrr_weight, sp_found};
`endif

  // Two-state grant FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_gnt_vld <= 1'b0;
      rd_gnt_pri <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= GRANT;
            rd_gnt_vld <= 1'b1;
            rd_gnt_pri <= pick_idx;
            busy       <= 1'b1;
          end
        end
        GRANT: begin
          if (pkt_done) begin
            state      <= IDLE;
            rd_gnt_vld <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          rd_gnt_vld <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/out_port_sched.md
# out_port_sched

Per-output-port packet scheduler for the 16-port SRAM switch. Each output port holds eight priority queues in shared SRAM. This block decides which queue the queue reader drains next, one whole packet at a time, using strict priority or weighted round robin as selected by `sp0_wrr1`. One instance sits between the queue manager's per-priority non-empty flags and the read-side packet reader of each output port.

## Interface

**Parameters**
- `num_of_priority`, default 8: number of priority queues per output port.
- `priority_width`, default 3: width of a queue index; must equal clog2(`num_of_priority`).
- `weight_width`, default 4: width of each WRR weight.

**Ports**
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `sp0_wrr1`, in, 1: mode select; 0 = strict priority, 1 = WRR.
- `q_nonempty`, in, `num_of_priority`: bit i is high when queue i holds at least one complete packet.
- `wrr_weight`, in, `num_of_priority*weight_width`: packets per round for each queue; slice i belongs to queue i.
- `ready`, in, 1: the downstream output port can accept a new packet.
- `pkt_done`, in, 1: one-cycle pulse from the reader when the eop word of the granted packet has been transferred.
- `rd_gnt_vld`, out, 1: a grant is active.
- `rd_gnt_pri`, out, `priority_width`: index of the granted queue.
- `busy`, out, 1: high while in GRANT.

## Operation

- Priority order: index 7 is the highest priority, index 0 the lowest.
- FSM has two states, IDLE and GRANT.
- **IDLE → GRANT** when `ready` is high and `|q_nonempty` is true. The pick is registered into `rd_gnt_pri`, and `rd_gnt_vld` goes high.
- **GRANT → IDLE** on `pkt_done`.
- In GRANT, `rd_gnt_pri` and `rd_gnt_vld` are held constant.
  - `ready`, `q_nonempty` and `sp0_wrr1` are ignored in GRANT.
- `pkt_done` in IDLE is ignored.
- `sp0_wrr1` is sampled only in IDLE.
  - A 0→1 change reloads all credits from `wrr_weight` and sets `rr_ptr` to `num_of_priority-1`.
- **Strict priority:** grant the highest set bit of `q_nonempty`.
- **WRR:**
  - State: one credit counter per queue (`weight_width` bits) and `rr_ptr`.
  - A queue is eligible when `q_nonempty[i]` is set and its credit is greater than 0.
  - If no non-empty queue is eligible, the block reloads all credits from the weights, treating a weight of 0 as 1. It arbitrates on the reloaded values in the same cycle.
  - The pick is the first eligible queue scanning downward from `rr_ptr`, wrapping from 0 to `num_of_priority-1`.
  - On grant, the granted queue's credit is decremented by 1.
  - If that credit reaches 0, `rr_ptr` moves to the granted index minus 1, wrapping 0 to `num_of_priority-1`. Otherwise `rr_ptr` is set to the granted index.
  - Credits of empty queues are retained until the next reload.

## Timing

- Reset values:
  - State IDLE.
  - `rd_gnt_vld` = 0, `rd_gnt_pri` = 0, `busy` = 0.
  - All credits = 0, so the first WRR decision reloads.
  - `rr_ptr` = `num_of_priority-1`.
- Grant latency: when `ready` is high and `q_nonempty` is non-zero in cycle N, `rd_gnt_vld` is high in cycle N+1.
- `pkt_done` is accepted in any GRANT cycle, including the first. `rd_gnt_vld` is low in the cycle after `pkt_done`. The earliest next grant is one cycle after that, giving one mandatory idle cycle between grants.
- Reset asserted mid-GRANT: every output returns to its reset value at the next edge. The in-flight grant is dropped, and the reader is reset by the same `rst_n`.
- Credit updates and `rr_ptr` updates take effect on the same edge as the grant.

## Configuration

- `SCHED_WRR_EN` defined: WRR logic is compiled in, including the credits, `rr_ptr` and weight decode, and `sp0_wrr1` selects the mode.
- `SCHED_WRR_EN` not defined: strict priority only. `sp0_wrr1` and `wrr_weight` are ignored, and no credit registers exist.

## Structure

- Package `sched_pkg` holds:
  - the state enum `sched_state_t` {IDLE, GRANT};
  - default constants for `num_of_priority`, `priority_width` and `weight_width`.
- Sub-module `rot_pick`: a combinational rotating picker. Inputs are a request vector and a start pointer; the output is the index of the first set bit scanning downward from the pointer, plus a found flag. It is used for WRR. Strict priority uses `rot_pick` with the pointer fixed at `num_of_priority-1`.

## Test plan

- Strict priority: `sp0_wrr1`=0, `q_nonempty`=8'b1000_0101, `ready`=1 → grant 7. After `pkt_done` with queue 7 still non-empty → grant 7 again. Clear bit 7 → grant 2, then grant 0.
- WRR: weight[7]=2, weight[6]=0, all other weights 1, all queues non-empty → grant order 7,7,6,5,4,3,2,1,0,7,7,… A reload occurs after the grant to queue 0.
- WRR with `q_nonempty`=8'b0000_0011 and all weights 3 → grant order 1,1,1,0,0,0, then a reload, then 1 again.
- `ready`=0 with `q_nonempty`=8'hFF → `rd_gnt_vld` stays 0. Raise `ready` in cycle N → `rd_gnt_vld`=1 in N+1. Drop `ready` during GRANT → grant held.
- `pkt_done` in the first GRANT cycle → `rd_gnt_vld`=0 the next cycle and 1 the cycle after. Assert `rst_n`=0 for one cycle mid-GRANT → `rd_gnt_vld`=0 and `busy`=0 at the next edge, and credits are cleared.
- Build without `SCHED_WRR_EN`, `sp0_wrr1`=1, `q_nonempty`=8'hFF → grants are always 7.
